if_fetch_unit: RTL and testbench

Instruction fetch unit that generates the fetch address stream, issues requests to instruction memory, and buffers returned words in a small prefetch queue. It drives the PC and instruction inputs of the IF/ID pipeline register and consumes that register's freeze (back-pressure) and the branch redirect from EX. An empty queue presents an all-zero bubble (PC 0, instruction 0), so the pipeline sees a NOP-equivalent.

---
 rtl/if_fetch_unit.sv | 82 ++++++++
 tb/tb_if_fetch_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with a DEPTH-entry prefetch queue, branch redirect and IF/ID freeze; `define IF_PERF_CNT_EN adds fetch_stall_cnt
module if_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_stall_cnt
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {FETCH, WAIT_SPACE} state_t;
  state_t          state, state_nx;
  logic [31:0]     fetch_pc;
  logic [31:0]     q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, count_nx;
  logic            enq, deq;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign mem_req   = !rst && state == FETCH;
  assign mem_addr  = fetch_pc;
  assign valid_out = count != '0;
  assign pc_out    = valid_out ? q_pc[head] : '0;
  assign instr_out = valid_out ? q_instr[head] : '0;
  // queue bookkeeping and next state; a redirect discards any completing response and flushes
  always_comb begin
    enq      = mem_req && mem_ready && !branch_taken;
    deq      = valid_out && !freeze && !branch_taken;
    count_nx = branch_taken ? '0 :
               (enq && !deq) ? count + CW'(1) :
               (!enq && deq) ? count - CW'(1) : count;
    state_nx = (branch_taken || count_nx < CW'(DEPTH)) ? FETCH : WAIT_SPACE;
  end
  // FSM state register
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else     state <= state_nx;
  // fetch address: reset, redirect, or advance on each accepted response
  always_ff @(posedge clk)
    if (rst)               fetch_pc <= RESET_PC;
    else if (branch_taken) fetch_pc <= {branch_addr[31:2], 2'b00};
    else if (enq)          fetch_pc <= fetch_pc + 32'd4;
  // queue pointers and occupancy
  always_ff @(posedge clk)
    if (rst || branch_taken) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= nxt(tail);
      if (deq) head <= nxt(head);
      count <= count_nx;
    end
  // queue storage, written at the tail on each accepted response
  always_ff @(posedge clk)
    if (enq) begin
      q_pc[tail]    <= fetch_pc + 32'd4;
      q_instr[tail] <= mem_rdata;
    end
`ifdef IF_PERF_CNT_EN
  // saturating count of cycles spent waiting on memory; survives redirects
  always_ff @(posedge clk)
    if (rst)                                                fetch_stall_cnt <= '0;
    else if (mem_req && !mem_ready && fetch_stall_cnt != '1) fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and random stimulus checked against a queue-based reference model
module tb_if_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h100;
  logic        clk = 0, rst = 1, freeze = 0, branch_taken = 0, mem_ready = 0;
  logic [31:0] branch_addr = 0, mem_rdata = 0;
  logic        mem_req, valid_out;
  logic [31:0] mem_addr, pc_out, instr_out;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_stall_cnt;
`endif
  int total = 0, bad = 0;
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  int          m_stall;
  if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .valid_out(valid_out),
    .pc_out(pc_out), .instr_out(instr_out)
`ifdef IF_PERF_CNT_EN
    , .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba, input logic rdy);
    logic [31:0] rd;
    logic [63:0] h;
    bit req;
    @(negedge clk);
    rd = $urandom;
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; mem_ready = rdy; mem_rdata = rd;
    #1;
    req = !r && mq.size() < DEPTH;
    h = mq.size() != 0 ? mq[0] : 64'h0;
    chk("mem_req", 32'(mem_req), 32'(req));
    chk("mem_addr", mem_addr, m_pc);
    chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
    chk("pc_out", pc_out, h[63:32]);
    chk("instr_out", instr_out, h[31:0]);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", 32'(fetch_stall_cnt), 32'(m_stall));
`endif
    if (r) begin
      mq.delete();
      m_pc = RESET_PC;
      m_stall = 0;
    end else begin
      if (req && !rdy && m_stall < 65535) m_stall++;
      if (b) begin
        mq.delete();
        m_pc = ba & 32'hFFFF_FFFC;
      end else begin
        if (mq.size() != 0 && !f) void'(mq.pop_front());
        if (req && rdy) begin
          mq.push_back({m_pc + 32'd4, rd});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask
  initial begin
    logic [31:0] ba;
    repeat (2) @(posedge clk);
    mq.delete();
    m_pc = RESET_PC;
    m_stall = 0;
    step(1, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 1);
    repeat (5) step(0, 1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h200, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h403, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h555, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: ba = 32'hFFFF_FFF8 | 32'($urandom_range(7));
        1: ba = 32'h403;
        default: ba = $urandom;
      endcase
      step($urandom_range(199) == 0, $urandom_range(2) == 0, $urandom_range(15) == 0, ba, $urandom_range(3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
